// File: rtl/product_collector_if.sv
// product_collector_if: operand-launch/column inputs and the streamed reduced-coefficient output.
interface product_collector_if #(
   parameter int N           = 8,
   parameter int INPUT_WIDTH = 8
);
   logic                              start;
   logic [2*N-2:0][INPUT_WIDTH-1:0]   c_values;
   logic                              busy;
   logic                              out_valid;
   logic                              out_ready;
   logic [INPUT_WIDTH-1:0]            out_data;
   logic [$clog2(N)-1:0]              out_index;
   logic                              out_last;
   logic                              done;
   modport master (
      output start, c_values, out_ready,
      input  busy, out_valid, out_data, out_index, out_last, done
   );
   modport slave (
      input  start, c_values, out_ready,
      output busy, out_valid, out_data, out_index, out_last, done
   );
endinterface

// File: rtl/product_collector.sv
// product_collector: waits out the multiplier pipeline, folds the linear convolution
// mod x^N+1 into an N-entry buffer and streams it out over a valid/ready handshake.
module product_collector #(
   parameter int N            = 8,
   parameter int INPUT_WIDTH  = 8,
   parameter int PIPE_LATENCY = 3
) (
   input logic                clk,
   input logic                nrst,
   product_collector_if.slave bus
);
   localparam int IW = $clog2(N);
   localparam int CW = $clog2(PIPE_LATENCY + 1) + 1;
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, STREAM = 2'd2;
   logic [1:0]                        state_q, state_d;
   logic [CW-1:0]                     cnt_q, cnt_d;
   logic [IW-1:0]                     idx_q, idx_d;
   logic [N-1:0][INPUT_WIDTH-1:0]     coef_q, coef_d, red;
   logic                              done_q, go, cap, xfer, fin;
   // Top coefficient has no c_{2N-1} partner to subtract.
   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_red
         if (i == N - 1) begin : g_top
            assign red[i] = bus.c_values[i];
         end else begin : g_sub
            assign red[i] = bus.c_values[i] - bus.c_values[i+N];
         end
      end
   endgenerate
   always_comb begin
      go      = state_q == IDLE && bus.start;
      cap     = state_q == WAIT && cnt_q == CW'(PIPE_LATENCY);
      xfer    = state_q == STREAM && bus.out_ready;
      fin     = xfer && idx_q == IW'(N - 1);
      state_d = go ? WAIT : cap ? STREAM : fin ? IDLE : state_q;
      cnt_d   = go ? CW'(1) : (state_q == WAIT && !cap) ? cnt_q + CW'(1) : cnt_q;
      idx_d   = xfer ? idx_q + IW'(1) : idx_q;
      coef_d  = cap ? red : coef_q;
   end
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         coef_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         coef_q  <= coef_d;
         done_q  <= fin;
      end
   end
   assign bus.busy      = state_q != IDLE;
   assign bus.out_valid = state_q == STREAM;
   assign bus.out_data  = bus.out_valid ? coef_q[idx_q] : '0;
   assign bus.out_index = idx_q;
   assign bus.out_last  = bus.out_valid && idx_q == IW'(N - 1);
   assign bus.done      = done_q;
endmodule

// File: doc/product_collector.md
PRODUCT_COLLECTOR -- requirements
Module: product_collector

Interface
- REQ-001: Parameter N, default 8: number of coefficients per polynomial; SHALL be a power of two and at least 2.
- REQ-002: Parameter INPUT_WIDTH, default 8: coefficient width in bits; all arithmetic SHALL be modulo 2^INPUT_WIDTH.
- REQ-003: Parameter PIPE_LATENCY, default 3: cycles from operand launch to valid column outputs; SHALL be at least 1.
- REQ-004: clk  input  1  sole clock; all state SHALL update on its rising edge.
- REQ-005: nrst  input  1  reset, asynchronous and active-low.
- REQ-006: start  input  1  single-cycle pulse: operands were presented to the addition columns this cycle.
- REQ-007: c_values  input  [2N-2:0][INPUT_WIDTH-1:0]  full linear-convolution column outputs; index k carries c_k.
- REQ-008: busy  output  1  high in every state except IDLE.
- REQ-009: out_valid  output  1  out_data, out_index and out_last are valid.
- REQ-010: out_ready  input  1  downstream accepts the current word.
- REQ-011: out_data  output  [INPUT_WIDTH-1:0]  reduced coefficient d_i.
- REQ-012: out_index  output  [$clog2(N)-1:0]  coefficient index i of out_data.
- REQ-013: out_last  output  1  high when out_index == N-1 and out_valid is high.
- REQ-014: done  output  1  single-cycle pulse after the final handshake.

Function
- REQ-015: The FSM SHALL have exactly three states, IDLE, WAIT and STREAM, and SHALL reset to IDLE.
- REQ-016: In IDLE, start=1 SHALL move the FSM to WAIT and load the latency counter with 1.
- REQ-017: In WAIT, the counter SHALL increment every cycle.
  - On the edge where counter == PIPE_LATENCY, the block SHALL capture the reduced vector and move to STREAM.
  - With start at cycle t, c_values SHALL therefore be sampled during cycle t+PIPE_LATENCY.
  - out_valid SHALL first be high in cycle t+PIPE_LATENCY+1.
- REQ-018: Negacyclic reduction mod x^N+1, with the capture stored in an N-entry register buffer:
  - d_i = (c_i - c_{i+N}) mod 2^INPUT_WIDTH for 0 <= i <= N-2;
  - d_{N-1} = c_{N-1}.
- REQ-019: In STREAM:
  - out_valid SHALL be high;
  - out_data SHALL equal d at out_index;
  - out_index SHALL start at 0.
- REQ-020: Handshake rule: a word transfers only in a cycle with out_valid=1 and out_ready=1.
  - On a transfer, out_index SHALL increment.
  - Without a transfer, out_data, out_index and out_last SHALL hold stable.
- REQ-021: A transfer with out_last=1 SHALL:
  - return the FSM to IDLE;
  - assert done for exactly the next cycle;
  - deassert out_valid in that next cycle.
- REQ-022: start asserted in WAIT or STREAM SHALL be ignored and SHALL NOT disturb the counter, buffer or index.
- REQ-023: start asserted in the same cycle done is high SHALL be accepted, because the FSM is already in IDLE.
- REQ-024: out_ready SHALL be a don't-care outside STREAM, and out_valid SHALL NOT depend combinationally on out_ready.
- REQ-025: The buffer SHALL update only at the WAIT->STREAM capture edge; c_values changing at any other time SHALL have no effect.

Reset
- REQ-026: nrst low SHALL immediately force, without waiting for a clock edge:
  - FSM = IDLE;
  - counter = 0 and out_index = 0;
  - busy = 0, out_valid = 0, out_last = 0, done = 0;
  - out_data = 0 and buffer = 0.
- REQ-027: nrst low during WAIT or STREAM SHALL abort the operation with no done pulse.
  - After nrst rises, the block SHALL accept a new start on the first clock edge.

Verification (N=4, INPUT_WIDTH=8, PIPE_LATENCY=3)
- REQ-028: Basic product, start at cycle 0 with c_values = [1,3,6,10,9,7,4] (c_0 first) and out_ready tied high.
  - Expected stream: 248, 252, 2, 10 with indices 0..3.
  - out_valid first high in cycle 4; out_last in cycle 7; done in cycle 8.
- REQ-029: Backpressure: same stimulus with out_ready low for cycles 4-6.
  - The block SHALL hold 248 at index 0 for cycles 4-6 and complete with done in cycle 11.
- REQ-030: Wrap-around: c_0=0, c_4=1, all other c=0.
  - d_0 SHALL be 255; the remaining coefficients SHALL be 0.
- REQ-031: Ignored start: pulse start again in cycles 2 and 5 of an operation.
  - The output stream and timing SHALL be identical to REQ-028, and exactly one done pulse SHALL occur.
- REQ-032: Reset mid-stream: drop nrst in cycle 5.
  - All outputs SHALL read 0 within the same cycle, with no done pulse.
  - A start after release SHALL produce a full correct stream.
- REQ-033: Back-to-back: start in the cycle done is high.
  - The second stream SHALL begin PIPE_LATENCY+1 cycles later with correct data.
